// File: rtl/mem_dump_tx_if.sv
// mem_dump_tx_if: groups the dump request, data-memory read port and
// outgoing byte stream of mem_dump_tx into one bundle.
// master = the dump transmitter, slave = the core/memory/sink side.
interface mem_dump_tx_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        word_cnt;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, word_cnt, mem_rdata, tx_ready,
    output mem_rd_en, mem_addr, tx_valid, tx_data, busy, done
  );

  modport slave (
    output start, base_addr, word_cnt, mem_rdata, tx_ready,
    input  mem_rd_en, mem_addr, tx_valid, tx_data, busy, done
  );
endinterface

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: data-memory dump transmitter for the 16-bit RISC core.
// After a start request it reads word_cnt words from data memory starting
// at base_addr (1-cycle read latency) and streams a framed byte sequence:
//   SOF, count, {hi, lo} per word, [checksum]
// over a valid/ready byte interface.
// Optional feature: define MEM_DUMP_CSUM_EN to append an XOR checksum of
// every accepted byte after SOF; without it the frame is 2 + 2*N bytes.
module mem_dump_tx #(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] SOF    = 8'hA5
) (
  input  logic            clk1,
  input  logic            rst,
  mem_dump_tx_if.master   bus
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR  = 4'd1,
    ST_CNT  = 4'd2,
    ST_RD   = 4'd3,
    ST_WAIT = 4'd4,
    ST_HI   = 4'd5,
    ST_LO   = 4'd6,
`ifdef MEM_DUMP_CSUM_EN
    ST_CSUM = 4'd7,
`endif
    ST_FIN  = 4'd8
  } state_t;

  state_t            state_r;

  // Frame parameters captured on the accepted start.
  logic [ADDR_W-1:0] base_r;
  logic [7:0]        cnt_r;
  logic [7:0]        idx_r;
  logic [15:0]       hold_r;

  // Registered outputs.
  logic              mem_rd_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              tx_valid_r;
  logic [7:0]        tx_data_r;
  logic              busy_r;
  logic              done_r;

  // Lookahead for the word loop.
  logic [7:0]        idx_next_s;
  logic              more_words_s;
  logic [ADDR_W-1:0] next_addr_s;

`ifdef MEM_DUMP_CSUM_EN
  logic [7:0]        csum_r;

  // Folds one accepted byte into the running frame checksum.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Next word index, "another word to go" test and next read address (wraps modulo 2^ADDR_W).
  always_comb begin
    idx_next_s   = idx_r + 8'd1;
    more_words_s = ({1'b0, idx_r} + 9'd1) < {1'b0, cnt_r};
    next_addr_s  = base_r + ADDR_W'(idx_next_s);
  end

  // Frame sequencer: owns every registered output and all frame state.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      base_r      <= '0;
      cnt_r       <= 8'd0;
      idx_r       <= 8'd0;
      hold_r      <= 16'd0;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= '0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef MEM_DUMP_CSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r      <= 1'b0;
          mem_rd_en_r <= 1'b0;
          if (bus.start) begin
            // Capture the request so later input changes cannot disturb this frame.
            base_r     <= bus.base_addr;
            cnt_r      <= bus.word_cnt;
            idx_r      <= 8'd0;
            busy_r     <= 1'b1;
            tx_valid_r <= 1'b1;
            tx_data_r  <= SOF;
`ifdef MEM_DUMP_CSUM_EN
            csum_r     <= 8'd0;
`endif
            state_r    <= ST_HDR;
          end else begin
            busy_r     <= 1'b0;
            tx_valid_r <= 1'b0;
          end
        end

        ST_HDR: begin
          if (bus.tx_ready) begin
            tx_data_r <= cnt_r;
            state_r   <= ST_CNT;
          end
        end

        ST_CNT: begin
          if (bus.tx_ready) begin
`ifdef MEM_DUMP_CSUM_EN
            csum_r <= csum_next(csum_r, tx_data_r);
`endif
            if (cnt_r == 8'd0) begin
`ifdef MEM_DUMP_CSUM_EN
              tx_data_r  <= csum_next(csum_r, tx_data_r);
              state_r    <= ST_CSUM;
`else
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_FIN;
`endif
            end else begin
              // Drop valid before reading: reads never overlap a presented byte.
              tx_valid_r  <= 1'b0;
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= base_r;
              state_r     <= ST_RD;
            end
          end
        end

        ST_RD: begin
          mem_rd_en_r <= 1'b0;
          state_r     <= ST_WAIT;
        end

        ST_WAIT: begin
          // Read data arrives one cycle after the strobe.
          hold_r     <= bus.mem_rdata;
          tx_valid_r <= 1'b1;
          tx_data_r  <= bus.mem_rdata[15:8];
          state_r    <= ST_HI;
        end

        ST_HI: begin
          if (bus.tx_ready) begin
`ifdef MEM_DUMP_CSUM_EN
            csum_r    <= csum_next(csum_r, tx_data_r);
`endif
            tx_data_r <= hold_r[7:0];
            state_r   <= ST_LO;
          end
        end

        ST_LO: begin
          if (bus.tx_ready) begin
`ifdef MEM_DUMP_CSUM_EN
            csum_r <= csum_next(csum_r, tx_data_r);
`endif
            if (more_words_s) begin
              idx_r       <= idx_next_s;
              tx_valid_r  <= 1'b0;
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= next_addr_s;
              state_r     <= ST_RD;
            end else begin
`ifdef MEM_DUMP_CSUM_EN
              tx_data_r  <= csum_next(csum_r, tx_data_r);
              state_r    <= ST_CSUM;
`else
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_FIN;
`endif
            end
          end
        end

`ifdef MEM_DUMP_CSUM_EN
        ST_CSUM: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= ST_FIN;
          end
        end
`endif

        ST_FIN: begin
          // done was raised on entry; this closes the one-cycle pulse.
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          mem_rd_en_r <= 1'b0;
          tx_valid_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: randomized self-checking bench for mem_dump_tx.
// Expected frames come from a queue-based model of the frame format;
// a byte-level monitor collects what the sink accepts and the reads issued.
module tb_mem_dump_tx;

`ifdef MEM_DUMP_CSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  logic clk1;
  logic rst;

  mem_dump_tx_if #(.ADDR_W(16)) bus ();

  mem_dump_tx #(.ADDR_W(16), .SOF(8'hA5)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus.master)
  );

  logic [15:0] memd [0:65535];

  int checks = 0;
  int errors = 0;

  logic [7:0]  got_q  [$];
  logic [15:0] addr_q [$];
  int          done_cnt   = 0;
  int          rd_ovl_cnt = 0;
  int          stab_cnt   = 0;
  int          busydone_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data  = 8'd0;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Data memory with one cycle of read latency; garbage when not read.
  always @(posedge clk1) begin
    if (bus.mem_rd_en) bus.mem_rdata <= memd[bus.mem_addr];
    else               bus.mem_rdata <= 16'($urandom);
  end

  // Sink-side monitor: accepted bytes, issued reads, handshake stability.
  always @(negedge clk1) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.mem_rd_en) addr_q.push_back(bus.mem_addr);
      if (bus.mem_rd_en && bus.tx_valid) rd_ovl_cnt <= rd_ovl_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.done && bus.busy) busydone_cnt <= busydone_cnt + 1;
      if (stall_prev && !(bus.tx_valid && bus.tx_data == prev_data)) stab_cnt <= stab_cnt + 1;
      stall_prev <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from IDLE and checks it against the frame-format model.
  task automatic run_frame(input logic [15:0] base, input logic [7:0] cnt, input int ready_pct,
                           input bit use_stall, input logic [7:0] stall_byte, input int poke_cycle);
    logic [7:0]  exp_q  [$];
    logic [15:0] exp_a  [$];
    logic [7:0]  cs;
    logic [15:0] a;
    int cyc, stall_left, d0, o0, s0, b0;
    bit fin, stalled;
    // Model: SOF, count, hi/lo of each word, XOR of everything after SOF.
    exp_q.push_back(8'hA5);
    exp_q.push_back(cnt);
    cs = cnt;
    for (int k = 0; k < int'(cnt); k++) begin
      a = base + 16'(k);
      exp_a.push_back(a);
      exp_q.push_back(memd[a][15:8]);
      exp_q.push_back(memd[a][7:0]);
      cs = cs ^ memd[a][15:8] ^ memd[a][7:0];
    end
    if (CSUM_ON != 0) exp_q.push_back(cs);

    got_q.delete();
    addr_q.delete();
    d0 = done_cnt; o0 = rd_ovl_cnt; s0 = stab_cnt; b0 = busydone_cnt;

    bus.base_addr = base;
    bus.word_cnt  = cnt;
    bus.start     = 1'b1;
    bus.tx_ready  = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk1); #1;
    bus.start     = 1'b0;
    bus.base_addr = 16'($urandom);
    bus.word_cnt  = 8'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("sof_valid", 32'(bus.tx_valid), 32'd1);
    check("sof_data", 32'(bus.tx_data), 32'hA5);

    cyc = 0; fin = 0; stalled = 0; stall_left = 0;
    while (!fin && cyc < 3000) begin
      if (use_stall && !stalled && bus.tx_valid && bus.tx_data == stall_byte) begin
        stalled = 1; stall_left = 3; bus.tx_ready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--; bus.tx_ready = 1'b0;
      end else begin
        bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
      end
      bus.start = (poke_cycle != 0 && cyc + 1 == poke_cycle);
      @(posedge clk1); #1;
      cyc++;
      if (bus.done) fin = 1;
    end
    bus.start = 1'b0;
    check("frame_done_seen", 32'(fin), 32'd1);
    check("busy_with_done", 32'(bus.busy), 32'd0);
    if (ready_pct >= 100 && !use_stall)
      check("frame_cycles", 32'(cyc), 32'(2 + 4 * int'(cnt) + CSUM_ON));

    bus.tx_ready = 1'b1;
    repeat (4) @(posedge clk1);
    #1;
    check("idle_valid", 32'(bus.tx_valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);

    check("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("nreads", 32'(addr_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      if (i < addr_q.size()) check($sformatf("addr%0d", i), 32'(addr_q[i]), 32'(exp_a[i]));
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("read_while_valid", 32'(rd_ovl_cnt - o0), 32'd0);
    check("stall_stability", 32'(stab_cnt - s0), 32'd0);
    check("busy_done_overlap", 32'(busydone_cnt - b0), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = 16'd0;
    bus.word_cnt = 8'd0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 65536; i++) memd[i] = 16'(i);
    bus.start = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    bus.start = 1'b0;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk1); #1;

    // Basic frame, memd[k]=k.
    run_frame(16'd4, 8'd3, 100, 1'b0, 8'h00, 0);
    // Backpressure on the first 0x04 byte.
    run_frame(16'd4, 8'd3, 100, 1'b1, 8'h04, 0);
    // Empty frame.
    run_frame(16'h0100, 8'd0, 100, 1'b0, 8'h00, 0);
    // Start pulsed during RD of word 0 is ignored.
    run_frame(16'h0010, 8'd2, 100, 1'b0, 8'h00, 3);

    for (int i = 0; i < 65536; i++) memd[i] = 16'($urandom);
    // Address wrap.
    run_frame(16'hFFFF, 8'd2, 100, 1'b0, 8'h00, 0);

    // Reset during the HI byte of word 1.
    bus.base_addr = 16'h0020;
    bus.word_cnt  = 8'd3;
    bus.tx_ready  = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk1); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk1);
    #1;
    check("mid_hi_valid", 32'(bus.tx_valid), 32'd1);
    check("mid_hi_data", 32'(bus.tx_data), 32'(memd[16'h0021][15:8]));
    rst = 1'b1;
    @(posedge clk1); #1;
    check("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk1); #1;
    run_frame(16'h0020, 8'd3, 100, 1'b0, 8'h00, 0);

    // Random frames with random backpressure.
    for (int r = 0; r < 8; r++)
      run_frame(16'($urandom), 8'($urandom_range(0, 20)), int'($urandom_range(40, 100)), 1'b0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
